// File: rtl/ball_spawner_pkg.sv
// ============================================================================
// ball_spawner_pkg : shared defaults, state encoding and LFSR/fold helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package ball_spawner_pkg;

  localparam int          SCREEN_W_DEF       = 640;
  localparam int          SCREEN_H_DEF       = 480;
  localparam int          BALL_SIZE_DEF      = 40;
  localparam int          TIMEOUT_CYCLES_DEF = 50_000_000;
  localparam int          COUNT_MAX_DEF      = 999;
  localparam logic [15:0] LFSR_SEED_DEF      = 16'hACE1;
  localparam int          COORD_W            = 10;
  localparam int          COUNT_W            = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Fibonacci taps 16/14/13/11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Single subtraction is enough because the range above the limit never exceeds the limit
  function automatic logic [COORD_W-1:0] fold(input logic [COORD_W-1:0] c,
                                              input logic [COORD_W-1:0] lim);
    return (c >= lim) ? c - lim : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16 : free-running 16-bit Fibonacci LFSR with a parameterised seed
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
  import ball_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/ball_spawner.sv
// ============================================================================
// ball_spawner : places a pseudo-random target, respawns it on hit or timeout
//                and keeps saturating hit/miss scores
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_spawner
  import ball_spawner_pkg::*;
#(
  parameter int          SCREEN_W       = SCREEN_W_DEF,
  parameter int          SCREEN_H       = SCREEN_H_DEF,
  parameter int          BALL_SIZE      = BALL_SIZE_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF,
  parameter int          COUNT_MAX      = COUNT_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               new_ball,
  output logic [COORD_W-1:0] BALL_X,
  output logic [COORD_W-1:0] BALL_Y,
  output logic               ball_valid,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  localparam int LIM_X = SCREEN_W - BALL_SIZE;
  localparam int LIM_Y = SCREEN_H - BALL_SIZE;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [COORD_W-1:0] C_LX      = COORD_W'(LIM_X);
  localparam logic [COORD_W-1:0] C_LY      = COORD_W'(LIM_Y);
  localparam logic [COUNT_W-1:0] C_CMAX    = COUNT_W'(COUNT_MAX);
  localparam logic [TO_W-1:0]    C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  if ((LIM_X > 1024) || ((1024 - LIM_X) > LIM_X)) begin : g_bad_fold_x
    $error("ball_spawner: SCREEN_W-BALL_SIZE cannot be folded from 10 LFSR bits");
  end
  if ((LIM_Y > 512) || ((512 - LIM_Y) > LIM_Y)) begin : g_bad_fold_y
    $error("ball_spawner: SCREEN_H-BALL_SIZE cannot be folded from 9 LFSR bits");
  end

  logic [15:0] lfsr_q;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  state_t             state_q,      state_d;
  logic [COORD_W-1:0] ball_x_q,     ball_x_d;
  logic [COORD_W-1:0] ball_y_q,     ball_y_d;
  logic               ball_valid_q, ball_valid_d;
  logic [COUNT_W-1:0] hit_count_q,  hit_count_d;
  logic [COUNT_W-1:0] miss_count_q, miss_count_d;
  logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
  logic               new_ball_q,   new_ball_d;
  logic               start_q,      start_d;

  logic               hit_edge;
  logic               start_rise;
  logic [COORD_W-1:0] fold_x;
  logic [COORD_W-1:0] fold_y;

  always_comb begin
    hit_edge   = new_ball & ~new_ball_q;
    start_rise = start & ~start_q;
    fold_x     = fold(lfsr_q[9:0], C_LX);
    fold_y     = fold({1'b0, lfsr_q[15:7]}, C_LY);
  end

  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    ball_valid_d = ball_valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    to_cnt_d     = to_cnt_q;
    new_ball_d   = new_ball;
    start_d      = start;

    // Dropping start parks the game but leaves position and score readable
    if (!start) begin
      state_d      = IDLE;
      ball_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ball_valid_d = 1'b0;
          if (start_rise) begin
            hit_count_d  = '0;
            miss_count_d = '0;
            state_d      = PICK;
          end
        end
        PICK: begin
          ball_x_d     = fold_x;
          ball_y_d     = fold_y;
          to_cnt_d     = '0;
          ball_valid_d = 1'b1;
          state_d      = SHOW;
        end
        SHOW: begin
          ball_valid_d = 1'b1;
          to_cnt_d     = to_cnt_q + TO_W'(1);
          if (hit_edge) begin
            if (hit_count_q < C_CMAX) hit_count_d = hit_count_q + COUNT_W'(1);
            ball_valid_d = 1'b0;
            state_d      = PICK;
          end else if (to_cnt_q == C_TO_LAST) begin
            if (miss_count_q < C_CMAX) miss_count_d = miss_count_q + COUNT_W'(1);
            ball_valid_d = 1'b0;
            state_d      = PICK;
          end
        end
        default: begin
          ball_valid_d = 1'b0;
          state_d      = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      ball_valid_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      to_cnt_q     <= '0;
      new_ball_q   <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      ball_valid_q <= ball_valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      to_cnt_q     <= to_cnt_d;
      new_ball_q   <= new_ball_d;
      start_q      <= start_d;
    end
  end

  assign BALL_X     = ball_x_q;
  assign BALL_Y     = ball_y_q;
  assign ball_valid = ball_valid_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

`default_nettype wire
